// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback scheduler slice.
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int IDX_W  = 5;
  localparam int CNT_W  = 16;

  // One buffered writeback result.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  index;
  } wb_entry_t;

  // Which channel wins the next same-index conflict.
  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries. The head is read straight
// from the storage array, so it is valid whenever the FIFO is non-empty.
// A full FIFO refuses a push even if it pops in the same cycle.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [CW-1:0]    CNT_MAX = CW'(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/wb_write_scheduler.sv
// Writeback scheduler feeding the dual-write register file.
// Channel A (ALU) always drives port 1, channel B (load unit) port 2.
// When both FIFO heads target the same index, only the channel named by the
// priority bit issues; the other follows next cycle so the later write wins.
// Optional build macro WB_CONFLICT_CNT_EN adds a saturating 16-bit
// conflict_count output.
module wb_write_scheduler #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_data,
  input  logic [IDX_W-1:0]  a_index,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic [IDX_W-1:0]  b_index,
  output logic              write1,
  output logic [DATA_W-1:0] write_data1,
  output logic [IDX_W-1:0]  write_index1,
  output logic              write2,
  output logic [DATA_W-1:0] write_data2,
  output logic [IDX_W-1:0]  write_index2,
  output logic              idle
`ifdef WB_CONFLICT_CNT_EN
  ,
  output logic [15:0]       conflict_count
`endif
);

  import wb_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t     a_entry;
  wb_entry_t     b_entry;
  wb_entry_t     a_head;
  wb_entry_t     b_head;
  logic          a_full;
  logic          a_empty;
  logic          b_full;
  logic          b_empty;
  logic [CW-1:0] a_count;
  logic [CW-1:0] b_count;
  logic          a_push;
  logic          b_push;
  logic          pop_a;
  logic          pop_b;
  logic          conflict;
  pri_t          pri;
  pri_t          pri_next;

  // Ready is forced low while clear is held.
  assign a_ready = !clear && !a_full;
  assign b_ready = !clear && !b_full;
  assign a_push  = a_valid && a_ready;
  assign b_push  = b_valid && b_ready;
  assign a_entry = '{data: a_data, index: a_index};
  assign b_entry = '{data: b_data, index: b_index};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clock      (clock),
    .clear      (clear),
    .push       (a_push),
    .push_entry (a_entry),
    .pop        (pop_a),
    .head       (a_head),
    .full       (a_full),
    .empty      (a_empty),
    .count      (a_count)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clock      (clock),
    .clear      (clear),
    .push       (b_push),
    .push_entry (b_entry),
    .pop        (pop_b),
    .head       (b_head),
    .full       (b_full),
    .empty      (b_empty),
    .count      (b_count)
  );

  // Issue decision and priority next-state from the current FIFO heads.
  always_comb begin
    conflict = 1'b0;
    pop_a    = 1'b0;
    pop_b    = 1'b0;
    pri_next = pri;
    conflict = !a_empty && !b_empty && (a_head.index == b_head.index);
    pop_a    = !a_empty && (!conflict || (pri == PRI_A));
    pop_b    = !b_empty && (!conflict || (pri == PRI_B));
    if (conflict) pri_next = (pri == PRI_A) ? PRI_B : PRI_A;
  end

  // Priority state register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) pri <= PRI_A;
    else       pri <= pri_next;
  end

  // Registered write ports; data and index hold while the enable is low.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      write1       <= 1'b0;
      write_data1  <= '0;
      write_index1 <= '0;
      write2       <= 1'b0;
      write_data2  <= '0;
      write_index2 <= '0;
    end else begin
      write1 <= pop_a;
      write2 <= pop_b;
      if (pop_a) begin
        write_data1  <= a_head.data;
        write_index1 <= a_head.index;
      end
      if (pop_b) begin
        write_data2  <= b_head.data;
        write_index2 <= b_head.index;
      end
    end
  end

  // Drain indicator: nothing buffered and nothing on the ports.
  always_comb begin
    idle = 1'b0;
    idle = (a_count == '0) && (b_count == '0) && !write1 && !write2;
  end

`ifdef WB_CONFLICT_CNT_EN
  // Saturating count of cycles in which a same-index conflict was resolved.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      conflict_count <= '0;
    end else if (conflict && (conflict_count != 16'hFFFF)) begin
      conflict_count <= conflict_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_write_scheduler.sv
// Bench for wb_write_scheduler: queue-based reference model, per-cycle
// compare on the falling edge, directed scenarios plus randomized traffic.
module tb_wb_write_scheduler;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 5;

  logic              clock = 1'b0;
  logic              clear = 1'b1;
  logic              a_valid = 1'b0;
  logic              a_ready;
  logic [DATA_W-1:0] a_data = '0;
  logic [IDX_W-1:0]  a_index = '0;
  logic              b_valid = 1'b0;
  logic              b_ready;
  logic [DATA_W-1:0] b_data = '0;
  logic [IDX_W-1:0]  b_index = '0;
  logic              write1;
  logic [DATA_W-1:0] write_data1;
  logic [IDX_W-1:0]  write_index1;
  logic              write2;
  logic [DATA_W-1:0] write_data2;
  logic [IDX_W-1:0]  write_index2;
  logic              idle;
`ifdef WB_CONFLICT_CNT_EN
  logic [15:0]       conflict_count;
`endif

  always #5 clock = ~clock;

  wb_write_scheduler #(.DEPTH(DEPTH), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clock        (clock),
    .clear        (clear),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_data       (a_data),
    .a_index      (a_index),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_data       (b_data),
    .b_index      (b_index),
    .write1       (write1),
    .write_data1  (write_data1),
    .write_index1 (write_index1),
    .write2       (write2),
    .write_data2  (write_data2),
    .write_index2 (write_index2),
    .idle         (idle)
`ifdef WB_CONFLICT_CNT_EN
    ,
    .conflict_count (conflict_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [DATA_W-1:0] d;
    logic [IDX_W-1:0]  i;
  } ent_t;

  ent_t              qa[$];
  ent_t              qb[$];
  bit                pri_b = 1'b0;
  logic              m_w1 = 1'b0;
  logic              m_w2 = 1'b0;
  logic [DATA_W-1:0] m_d1 = '0;
  logic [DATA_W-1:0] m_d2 = '0;
  logic [IDX_W-1:0]  m_i1 = '0;
  logic [IDX_W-1:0]  m_i2 = '0;
  int                m_cnt = 0;
  bit                acc_a = 1'b0;
  bit                acc_b = 1'b0;

  always @(posedge clock or posedge clear) begin
    if (clear) begin
      qa.delete();
      qb.delete();
      pri_b = 1'b0;
      m_w1 = 1'b0; m_w2 = 1'b0;
      m_d1 = '0;   m_d2 = '0;
      m_i1 = '0;   m_i2 = '0;
      m_cnt = 0;
      acc_a = 1'b0; acc_b = 1'b0;
    end else begin : step
      bit ha, hb, conf, pa, pb;
      ha   = (qa.size() > 0);
      hb   = (qb.size() > 0);
      conf = ha && hb && (qa[0].i == qb[0].i);
      pa   = ha && (!conf || !pri_b);
      pb   = hb && (!conf || pri_b);
      acc_a = a_valid && (qa.size() < DEPTH);
      acc_b = b_valid && (qb.size() < DEPTH);
      m_w1 = pa;
      m_w2 = pb;
      if (pa) begin m_d1 = qa[0].d; m_i1 = qa[0].i; void'(qa.pop_front()); end
      if (pb) begin m_d2 = qb[0].d; m_i2 = qb[0].i; void'(qb.pop_front()); end
      if (acc_a) qa.push_back('{d: a_data, i: a_index});
      if (acc_b) qb.push_back('{d: b_data, i: b_index});
      if (conf) begin
        pri_b = !pri_b;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    chk("write1", write1, m_w1);
    chk("write2", write2, m_w2);
    chk("write_data1", write_data1, m_d1);
    chk("write_index1", write_index1, m_i1);
    chk("write_data2", write_data2, m_d2);
    chk("write_index2", write_index2, m_i2);
    chk("a_ready", a_ready, !clear && (qa.size() < DEPTH));
    chk("b_ready", b_ready, !clear && (qb.size() < DEPTH));
    chk("idle", idle, (qa.size() == 0) && (qb.size() == 0) && !m_w1 && !m_w2);
`ifdef WB_CONFLICT_CNT_EN
    chk("conflict_count", conflict_count, 64'(m_cnt));
`endif
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic drive_a(input bit v, input logic [DATA_W-1:0] d, input logic [IDX_W-1:0] i);
    a_valid = v; a_data = d; a_index = i;
  endtask

  task automatic drive_b(input bit v, input logic [DATA_W-1:0] d, input logic [IDX_W-1:0] i);
    b_valid = v; b_data = d; b_index = i;
  endtask

  logic [DATA_W-1:0] got_b[$];
  int                nb;
  bit                saw_full;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    tick(); tick();
    chk("rst_write1", write1, 0);
    chk("rst_write2", write2, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_idle", idle, 1);
    clear = 1'b0;
    tick();
    chk("post_rst_ready", {a_ready, b_ready}, 2'b11);

    // single A
    drive_a(1, 255, 0);
    tick();
    drive_a(0, 0, 0);
    chk("single_before", write1, 0);
    tick();
    chk("single_w1", write1, 1);
    chk("single_d1", write_data1, 255);
    chk("single_i1", write_index1, 0);
    chk("single_w2", write2, 0);
    tick();
    chk("single_one_cycle", write1, 0);

    // dual, distinct indices
    drive_a(1, 255, 3);
    drive_b(1, 200, 7);
    tick();
    drive_a(0, 0, 0); drive_b(0, 0, 0);
    tick();
    chk("dual_w", {write1, write2}, 2'b11);
    chk("dual_d1", write_data1, 255);
    chk("dual_i1", write_index1, 3);
    chk("dual_d2", write_data2, 200);
    chk("dual_i2", write_index2, 7);
    tick();

    // clear mid-traffic
    for (int k = 0; k < 3; k++) begin
      drive_a(1, 32'h10 + k, 1);
      drive_b(1, 32'h20 + k, 2);
      tick();
    end
    drive_a(0, 0, 0); drive_b(0, 0, 0);
    clear = 1'b1;
    #1;
    chk("clr_w_drop", {write1, write2}, 2'b00);
    chk("clr_ready", {a_ready, b_ready}, 2'b00);
    chk("clr_idle", idle, 1);
    tick();
    clear = 1'b0;
    tick();
    chk("clr_ready_back", {a_ready, b_ready}, 2'b11);
    tick();
    chk("clr_no_stale", {write1, write2}, 2'b00);
    chk("clr_idle_after", idle, 1);

    // conflict, twice
    drive_a(1, 255, 0); drive_b(1, 200, 0);
    tick();
    drive_a(0, 0, 0); drive_b(0, 0, 0);
    tick();
    chk("conf1_first", {write1, write2}, 2'b10);
    chk("conf1_d1", write_data1, 255);
    tick();
    chk("conf1_second", {write1, write2}, 2'b01);
    chk("conf1_d2", write_data2, 200);
    tick();
    drive_a(1, 255, 0); drive_b(1, 200, 0);
    tick();
    drive_a(0, 0, 0); drive_b(0, 0, 0);
    tick();
    chk("conf2_first_b", {write1, write2}, 2'b01);
    tick();
    chk("conf2_second_a", {write1, write2}, 2'b10);
`ifdef WB_CONFLICT_CNT_EN
    chk("conf_count2", conflict_count, 2);
`endif
    tick();

    // full: B throttled by same-index conflicts, values held until accepted
    nb = 0;
    saw_full = 1'b0;
    got_b.delete();
    drive_b(1, 1000, 5);
    for (int c = 0; c < 80 && nb < 8; c++) begin
      drive_a(1, $urandom, 5);
      tick();
      if (write2) got_b.push_back(write_data2);
      if (acc_b) nb++;
      if (!b_ready) saw_full = 1'b1;
      b_data = 1000 + nb;
      b_valid = (nb < 8);
    end
    drive_a(0, 0, 0); drive_b(0, 0, 0);
    for (int c = 0; c < 20; c++) begin
      tick();
      if (write2) got_b.push_back(write_data2);
    end
    chk("full_seen", saw_full, 1);
    chk("full_accepts", nb, 8);
    chk("full_order_cnt", got_b.size(), 8);
    for (int k = 0; k < 8 && k < got_b.size(); k++)
      chk("full_order", got_b[k], 1000 + k);

    // drain: 6-entry burst on A
    for (int k = 0; k < 6; k++) begin
      drive_a(1, 500 + k, 5'(k));
      tick();
      chk("drain_busy", idle, 0);
    end
    drive_a(0, 0, 0);
    tick();
    chk("drain_last_w1", write1, 1);
    chk("drain_last_d1", write_data1, 505);
    chk("drain_last_busy", idle, 0);
    tick();
    chk("drain_idle", idle, 1);

    // randomized traffic with occasional clear
    for (int n = 0; n < 3000; n++) begin
      drive_a($urandom_range(0, 99) < 60, $urandom, 5'($urandom_range(0, 3)));
      drive_b($urandom_range(0, 99) < 60, $urandom, 5'($urandom_range(0, 3)));
      clear = ($urandom_range(0, 299) == 0);
      tick();
    end
    clear = 1'b0;
    drive_a(0, 0, 0); drive_b(0, 0, 0);
    for (int c = 0; c < 20; c++) tick();
    chk("final_idle", idle, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
